alu_arbiter: RTL

Two-port arbiter and issue sequencer that shares the single combinational 32-bit ALU between the pipeline EX stage (port 0) and a secondary requester such as a multi-cycle address/iterative unit (port 1). Accepts one operation per cycle via valid/ready, registers operands into an issue stage that drives the ALU, then registers the ALU result into a response stage tagged with the winning port. Sits between both requesters and the ALU instance in the datapath.

---
 rtl/alu_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// A valid/ready handshake accepts at most one op per cycle into an issue stage
// (S1). S1 drives the ALU, and a response stage (S2) registers the result
// tagged with the winning port. Latency from acceptance to response is 2 cycles.
//
// Optional feature, controlled by the macro ALU_ARB_STARVE_EN:
//   undefined -> strict port 0 priority (port 1 may starve)
//   defined   -> a 4-bit wait counter gives port 1 priority after MAX_WAIT refusals
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   stall               blocks new acceptance; in-flight ops still drain
//   req{0,1}_valid/code/a/b, req{0,1}_ready   requester handshakes
//   alu_code/alu_a/alu_b -> ALU;  alu_result/alu_overflow <- ALU
//   rsp{0,1}_valid      one-cycle response strobe per port
//   rsp_result, rsp_overflow   registered result, overflow gated to add/sub
module alu_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req0_valid,
  input  logic [4:0]  req0_code,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_code,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic [4:0]  alu_code,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow
);

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 5;
  localparam int unsigned WCW = 4;

  localparam logic [CW-1:0]  CODE_ADD = 5'b00000;
  localparam logic [CW-1:0]  CODE_SUB = 5'b00101;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  // Issue stage (S1)
  logic          s1_valid_q, s1_valid_d;
  logic          s1_port_q,  s1_port_d;
  logic [CW-1:0] s1_code_q,  s1_code_d;
  logic [DW-1:0] s1_a_q,     s1_a_d;
  logic [DW-1:0] s1_b_q,     s1_b_d;

  // Response stage (S2)
  logic          s2_valid_q,   s2_valid_d;
  logic          s2_port_q,    s2_port_d;
  logic [DW-1:0] rsp_result_q, rsp_result_d;
  logic          rsp_ovf_q,    rsp_ovf_d;

  logic can_issue_c;
  logic prio1_c;
  logic xfer_c;

`ifdef ALU_ARB_STARVE_EN
  logic [WCW-1:0] wait_q, wait_d;

  // Port 1 overtakes port 0 once it has been refused MAX_WAIT times
  assign prio1_c = (wait_q == WAIT_MAX);

  // Wait counter: stall cycles hold; a port 1 transfer or idle port 1 clears
  always_comb begin
    wait_d = wait_q;
    if (!stall) begin
      if (!req1_valid || req1_ready) begin
        wait_d = '0;
      end else if (wait_q < WAIT_MAX) begin
        wait_d = wait_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic [WCW-1:0] unused_wait_max;

  // Strict port 0 priority; the starvation limit has no effect in this build
  assign prio1_c         = 1'b0;
  assign unused_wait_max = WAIT_MAX;
`endif

  // Grant: ready is gated by reset so the outputs read 0 while it is asserted
  always_comb begin
    can_issue_c = !reset && !stall;
    req0_ready  = can_issue_c && req0_valid && !(prio1_c && req1_valid);
    req1_ready  = can_issue_c && req1_valid && (!req0_valid || prio1_c);
    xfer_c      = req0_ready || req1_ready;
  end

  // S1 next state: load the winner; without a transfer only the valid drops
  always_comb begin
    s1_valid_d = xfer_c;
    s1_port_d  = s1_port_q;
    s1_code_d  = s1_code_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (req1_ready) begin
      s1_port_d = 1'b1;
      s1_code_d = req1_code;
      s1_a_d    = req1_a;
      s1_b_d    = req1_b;
    end else if (req0_ready) begin
      s1_port_d = 1'b0;
      s1_code_d = req0_code;
      s1_a_d    = req0_a;
      s1_b_d    = req0_b;
    end
  end

  // S2 next state: overflow only means something for add and sub
  always_comb begin
    s2_valid_d   = s1_valid_q;
    s2_port_d    = s1_port_q;
    rsp_result_d = alu_result;
    rsp_ovf_d    = alu_overflow && ((s1_code_q == CODE_ADD) || (s1_code_q == CODE_SUB));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_port_q    <= 1'b0;
      s1_code_q    <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_port_q    <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_port_q    <= s1_port_d;
      s1_code_q    <= s1_code_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_port_q    <= s2_port_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  // ALU operands are zeroed whenever the issue stage is empty
  assign alu_code = s1_valid_q ? s1_code_q : '0;
  assign alu_a    = s1_valid_q ? s1_a_q    : '0;
  assign alu_b    = s1_valid_q ? s1_b_q    : '0;

  assign rsp0_valid   = s2_valid_q && !s2_port_q;
  assign rsp1_valid   = s2_valid_q &&  s2_port_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_ovf_q;

endmodule
